// File: rtl/dram_sequencer.sv
// Job controller that loads a UART image into DRAM, runs the processor, then
// streams a DRAM window back out over UART, owning the single DRAM port throughout.
module dram_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int LOAD_BYTES = 256,
    parameter int DUMP_BASE  = 0,
    parameter int DUMP_BYTES = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              processor_done,
    output logic              enable_processor,
    input  logic [ADDR_W-1:0] DRAM_address_processor,
    input  logic [7:0]        DRAM_output_data,
    input  logic              write_DRAM,
    output logic [ADDR_W-1:0] dram_address,
    output logic [7:0]        dram_wdata,
    output logic              dram_we,
    input  logic [7:0]        dram_rdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        DUMP_RD  = 3'd3,
        DUMP_CAP = 3'd4,
        DUMP_TX  = 3'd5,
        DONE     = 3'd6
    } state_t;

    // Pointers carry one extra bit so a full 2^ADDR_W count is representable.
    localparam logic [ADDR_W:0]   LOAD_END  = (ADDR_W+1)'(LOAD_BYTES);
    localparam logic [ADDR_W:0]   DUMP_LAST = (ADDR_W+1)'(DUMP_BYTES - 1);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DUMP_BASE);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W:0]   load_ptr;
    logic [ADDR_W:0]   dump_ptr;
    logic [ADDR_W-1:0] seq_address;
    logic [7:0]        seq_wdata;
    logic              seq_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= IDLE;
            load_ptr         <= '0;
            dump_ptr         <= '0;
            seq_address      <= '0;
            seq_wdata        <= '0;
            seq_we           <= 1'b0;
            tx_valid         <= 1'b0;
            tx_data          <= '0;
            enable_processor <= 1'b0;
            done             <= 1'b0;
        end else begin
            seq_we <= 1'b0;
            case (state_q)
                IDLE: begin
                    load_ptr <= '0;
                    dump_ptr <= '0;
                    if (start) state_q <= LOAD;
                end
                // The final byte's write cycle is still spent in LOAD; RUN follows it.
                LOAD: begin
                    if (load_ptr == LOAD_END) begin
                        state_q          <= RUN;
                        enable_processor <= 1'b1;
                    end else if (rx_valid) begin
                        seq_we      <= 1'b1;
                        seq_address <= load_ptr[ADDR_W-1:0];
                        seq_wdata   <= rx_data;
                        load_ptr    <= load_ptr + PTR_ONE;
                    end
                end
                RUN: begin
                    if (processor_done) begin
                        state_q          <= DUMP_RD;
                        enable_processor <= 1'b0;
                        seq_address      <= BASE_ADDR + dump_ptr[ADDR_W-1:0];
                    end
                end
                DUMP_RD: state_q <= DUMP_CAP;
                DUMP_CAP: begin
                    tx_data  <= dram_rdata;
                    tx_valid <= 1'b1;
                    state_q  <= DUMP_TX;
                end
                DUMP_TX: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (dump_ptr == DUMP_LAST) begin
                            state_q <= DONE;
                            done    <= 1'b1;
                        end else begin
                            dump_ptr    <= dump_ptr + PTR_ONE;
                            seq_address <= BASE_ADDR + dump_ptr[ADDR_W-1:0] + ADDR_ONE;
                            state_q     <= DUMP_RD;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state_q  <= LOAD;
                        done     <= 1'b0;
                        load_ptr <= '0;
                        dump_ptr <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The processor owns the DRAM port combinationally only while running.
    assign dram_address = (state_q == RUN) ? DRAM_address_processor : seq_address;
    assign dram_wdata   = (state_q == RUN) ? DRAM_output_data : seq_wdata;
    assign dram_we      = (state_q == RUN) ? write_DRAM : seq_we;

    assign busy  = (state_q != IDLE) && (state_q != DONE);
    assign state = state_q;

endmodule

// File: tb/tb_dram_sequencer.sv
// Directed bench for dram_sequencer: three jobs covering load, processor pass-through,
// dump handshaking with stalls, restart from DONE and reset in the middle of a load.
module tb_dram_sequencer;

    localparam int ADDR_W = 8;

    logic              clock;
    logic              reset;
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              tx_ready;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              processor_done;
    logic              enable_processor;
    logic [ADDR_W-1:0] DRAM_address_processor;
    logic [7:0]        DRAM_output_data;
    logic              write_DRAM;
    logic [ADDR_W-1:0] dram_address;
    logic [7:0]        dram_wdata;
    logic              dram_we;
    logic [7:0]        dram_rdata;
    logic              busy;
    logic              done;
    logic [2:0]        state;

    int check_count = 0;
    int pass_count  = 0;

    logic [7:0] mem [256];
    logic [7:0] tx_log [8];
    int         tx_time [8];
    int         tx_count = 0;
    int         cycle_count = 0;

    logic [7:0] job1_bytes [4];
    logic [7:0] job2_bytes [4];

    dram_sequencer #(
        .ADDR_W    (ADDR_W),
        .LOAD_BYTES(4),
        .DUMP_BASE (16),
        .DUMP_BYTES(2)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .start                 (start),
        .rx_valid              (rx_valid),
        .rx_data               (rx_data),
        .tx_ready              (tx_ready),
        .tx_valid              (tx_valid),
        .tx_data               (tx_data),
        .processor_done        (processor_done),
        .enable_processor      (enable_processor),
        .DRAM_address_processor(DRAM_address_processor),
        .DRAM_output_data      (DRAM_output_data),
        .write_DRAM            (write_DRAM),
        .dram_address          (dram_address),
        .dram_wdata            (dram_wdata),
        .dram_we               (dram_we),
        .dram_rdata            (dram_rdata),
        .busy                  (busy),
        .done                  (done),
        .state                 (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read DRAM model: read data appears one cycle after the address.
    always @(posedge clock) begin
        if (dram_we) mem[dram_address] <= dram_wdata;
        dram_rdata <= mem[dram_address];
    end

    // Logs every Tx handshake with the cycle it happened in.
    always @(posedge clock) begin
        cycle_count <= cycle_count + 1;
        if (!reset && tx_valid && tx_ready && tx_count < 8) begin
            tx_log[tx_count]  <= tx_data;
            tx_time[tx_count] <= cycle_count;
            tx_count          <= tx_count + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge clock);
    endtask

    task automatic checkResetState();
        checkOutput("rst_state", 32'(state), 0);
        checkOutput("rst_tx_valid", 32'(tx_valid), 0);
        checkOutput("rst_tx_data", 32'(tx_data), 0);
        checkOutput("rst_enable", 32'(enable_processor), 0);
        checkOutput("rst_addr", 32'(dram_address), 0);
        checkOutput("rst_wdata", 32'(dram_wdata), 0);
        checkOutput("rst_we", 32'(dram_we), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        job1_bytes[0] = 8'h11; job1_bytes[1] = 8'h22; job1_bytes[2] = 8'h33; job1_bytes[3] = 8'h44;
        job2_bytes[0] = 8'h77; job2_bytes[1] = 8'h66; job2_bytes[2] = 8'h55; job2_bytes[3] = 8'h44;

        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        processor_done = 1'b0; DRAM_address_processor = '0; DRAM_output_data = 8'h00;
        write_DRAM = 1'b0;
        applyStimulus(2);
        checkResetState();
        reset = 1'b0;
        applyStimulus(1);

        // Processor write strobe while IDLE must not reach the DRAM.
        DRAM_address_processor = 8'h10; DRAM_output_data = 8'hA5; write_DRAM = 1'b1;
        #1 checkOutput("idle_we_blocked", 32'(dram_we), 0);
        applyStimulus(1);
        write_DRAM = 1'b0;

        // Job 1: load four bytes back to back.
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("j1_state_load", 32'(state), 1);
        checkOutput("j1_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = job1_bytes[i];
            applyStimulus(1);
            checkOutput("j1_we", 32'(dram_we), 1);
            checkOutput("j1_addr", 32'(dram_address), 32'(i));
            checkOutput("j1_wdata", 32'(dram_wdata), 32'(job1_bytes[i]));
        end
        checkOutput("j1_last_write_in_load", 32'(state), 1);
        rx_data = 8'h99;
        applyStimulus(1);
        checkOutput("j1_state_run", 32'(state), 2);
        checkOutput("j1_enable", 32'(enable_processor), 1);
        applyStimulus(1);
        rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) checkOutput("j1_mem", 32'(mem[i]), 32'(job1_bytes[i]));
        checkOutput("j1_extra_rx_dropped", 32'(mem[4]), 0);

        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("run_ignores_start", 32'(state), 2);

        // Processor writes two bytes; the second lands in the processor_done cycle.
        DRAM_address_processor = 8'h10; DRAM_output_data = 8'hA5; write_DRAM = 1'b1;
        #1 checkOutput("run_pass_we", 32'(dram_we), 1);
        checkOutput("run_pass_addr", 32'(dram_address), 32'h10);
        checkOutput("run_pass_wdata", 32'(dram_wdata), 32'hA5);
        applyStimulus(1);
        DRAM_address_processor = 8'h11; DRAM_output_data = 8'h5A; processor_done = 1'b1;
        applyStimulus(1);
        write_DRAM = 1'b0; processor_done = 1'b0;
        checkOutput("j1_state_dump_rd", 32'(state), 3);
        checkOutput("j1_enable_low", 32'(enable_processor), 0);
        checkOutput("j1_mem_10", 32'(mem[16]), 32'hA5);
        checkOutput("j1_mem_11", 32'(mem[17]), 32'h5A);
        checkOutput("j1_dump_addr0", 32'(dram_address), 32'h10);
        checkOutput("j1_dump_we", 32'(dram_we), 0);
        applyStimulus(1);
        checkOutput("j1_state_cap", 32'(state), 4);
        applyStimulus(1);
        checkOutput("j1_tx_valid0", 32'(tx_valid), 1);
        checkOutput("j1_tx_data0", 32'(tx_data), 32'hA5);
        applyStimulus(1);
        checkOutput("j1_dump_addr1", 32'(dram_address), 32'h11);
        checkOutput("j1_tx_valid_drop", 32'(tx_valid), 0);
        applyStimulus(2);
        checkOutput("j1_tx_data1", 32'(tx_data), 32'h5A);
        applyStimulus(1);
        checkOutput("j1_done", 32'(done), 1);
        checkOutput("j1_state_done", 32'(state), 6);
        checkOutput("j1_busy_done", 32'(busy), 0);
        checkOutput("j1_tx_count", 32'(tx_count), 2);
        checkOutput("j1_tx_log0", 32'(tx_log[0]), 32'hA5);
        checkOutput("j1_tx_log1", 32'(tx_log[1]), 32'h5A);
        checkOutput("j1_tx_spacing", 32'(tx_time[1] - tx_time[0]), 3);

        // Job 2: restart straight from DONE, then stall the first Tx byte.
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("j2_state_load", 32'(state), 1);
        checkOutput("j2_done_clear", 32'(done), 0);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_data = job2_bytes[i];
            applyStimulus(1);
            checkOutput("j2_addr", 32'(dram_address), 32'(i));
        end
        rx_valid = 1'b0;
        applyStimulus(1);
        checkOutput("j2_state_run", 32'(state), 2);
        processor_done = 1'b1; tx_ready = 1'b0;
        applyStimulus(1);
        processor_done = 1'b0;
        checkOutput("j2_dump_addr0", 32'(dram_address), 32'h10);
        applyStimulus(2);
        for (int k = 0; k < 5; k++) begin
            checkOutput("j2_stall_state", 32'(state), 5);
            checkOutput("j2_stall_valid", 32'(tx_valid), 1);
            checkOutput("j2_stall_data", 32'(tx_data), 32'hA5);
            applyStimulus(1);
        end
        checkOutput("j2_no_tx_during_stall", 32'(tx_count), 2);
        tx_ready = 1'b1;
        applyStimulus(1);
        checkOutput("j2_one_transfer", 32'(tx_count), 3);
        checkOutput("j2_after_hs_state", 32'(state), 3);
        applyStimulus(3);
        checkOutput("j2_state_done", 32'(state), 6);
        checkOutput("j2_tx_count", 32'(tx_count), 4);
        checkOutput("j2_tx_log2", 32'(tx_log[2]), 32'hA5);
        checkOutput("j2_tx_log3", 32'(tx_log[3]), 32'h5A);

        // Job 3: reset after two loaded bytes while a third write is pending.
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hC1;
        applyStimulus(1);
        rx_data = 8'hC2;
        applyStimulus(1);
        checkOutput("j3_addr1", 32'(dram_address), 1);
        rx_data = 8'hC3; reset = 1'b1;
        applyStimulus(1);
        rx_valid = 1'b0; reset = 1'b0;
        checkResetState();
        applyStimulus(1);
        checkOutput("j3_mem0", 32'(mem[0]), 32'hC1);
        checkOutput("j3_mem1", 32'(mem[1]), 32'hC2);
        checkOutput("j3_pending_dropped", 32'(mem[2]), 32'h55);
        start = 1'b1;
        applyStimulus(1);
        start = 1'b0;
        checkOutput("j3_restart_load", 32'(state), 1);
        rx_valid = 1'b1; rx_data = 8'hE0;
        applyStimulus(1);
        rx_valid = 1'b0;
        checkOutput("j3_restart_we", 32'(dram_we), 1);
        checkOutput("j3_restart_addr", 32'(dram_address), 0);
        checkOutput("j3_restart_wdata", 32'(dram_wdata), 32'hE0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/dram_sequencer.md
# dram_sequencer

Top-level run controller and DRAM owner for the processor system. It sequences a full job: program/data image loaded from the UART receiver into DRAM, processor run, then a result window streamed from DRAM to the UART transmitter. It also multiplexes the single DRAM port between itself (load/dump) and the processor (run). It sits between the processor, the DRAM and the UART Rx/Tx blocks, and drives the processor's `enable_processor`.

## Interface
- `ADDR_W`, 16: DRAM address width.
- `LOAD_BYTES`, 256: bytes written during load, starting at address 0. Must be 1..2^ADDR_W.
- `DUMP_BASE`, 0: first DRAM address streamed out.
- `DUMP_BYTES`, 256: bytes streamed out. Must be 1..2^ADDR_W, and `DUMP_BASE`+`DUMP_BYTES` must be ≤ 2^ADDR_W.

Ports:
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  job start pulse.
- `rx_valid`  in  1  UART Rx byte strobe, one cycle per byte.
- `rx_data`  in  8  UART Rx byte.
- `tx_ready`  in  1  UART Tx can accept a byte.
- `tx_valid`  out  1  byte offered to Tx.
- `tx_data`  out  8  byte to Tx.
- `processor_done`  in  1  processor has finished.
- `enable_processor`  out  1  processor run enable.
- `DRAM_address_processor`  in  ADDR_W  processor DRAM address.
- `DRAM_output_data`  in  8  processor write data.
- `write_DRAM`  in  1  processor write strobe.
- `dram_address`  out  ADDR_W  DRAM address.
- `dram_wdata`  out  8  DRAM write data.
- `dram_we`  out  1  DRAM write enable.
- `dram_rdata`  in  8  DRAM read data. Synchronous read: valid 1 cycle after the address is presented.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `state`  out  3  current state, for debug/LEDs.

## Operation
- State encodings: IDLE=0, LOAD=1, RUN=2, DUMP_RD=3, DUMP_CAP=4, DUMP_TX=5, DONE=6.
- **IDLE**
  - `start` moves to LOAD.
  - `load_ptr` and `dump_ptr` are cleared.
- **LOAD**
  - Each `rx_valid` cycle registers a write: in the next cycle `dram_we`=1, `dram_address`=`load_ptr`, `dram_wdata`=`rx_data`.
  - `load_ptr` increments on each write.
  - Back-to-back `rx_valid` is accepted, up to one byte per cycle.
  - When byte number `LOAD_BYTES` is accepted, the state moves to RUN one cycle after that byte's write cycle.
- **RUN**
  - `enable_processor`=1, registered.
  - The DRAM port passes through combinationally: `dram_address`=`DRAM_address_processor`, `dram_wdata`=`DRAM_output_data`, `dram_we`=`write_DRAM`.
  - On `processor_done`, move to DUMP_RD; `enable_processor` is 0 from the next cycle.
- **DUMP_RD**
  - `dram_address`=`DUMP_BASE`+`dump_ptr`, `dram_we`=0.
  - Move to DUMP_CAP.
- **DUMP_CAP**
  - `tx_data` <= `dram_rdata`.
  - Move to DUMP_TX.
- **DUMP_TX**
  - `tx_valid`=1; `tx_data` is held stable.
  - On `tx_valid`&&`tx_ready`:
    - if `dump_ptr`=`DUMP_BYTES`-1, move to DONE;
    - otherwise `dump_ptr`++ and move to DUMP_RD.
- **DONE**
  - `done`=1.
  - `start` moves to LOAD with both pointers cleared, so a new job starts with no pass through IDLE.
- Pointers are ADDR_W+1 bits wide, so 2^ADDR_W counts do not wrap. The DRAM address is the low ADDR_W bits.
- Ignored inputs:
  - `start` outside IDLE/DONE.
  - `rx_valid` outside LOAD.
  - `write_DRAM` outside RUN (`dram_we` is forced 0).
  - `processor_done` outside RUN.
  - `tx_ready` outside DUMP_TX.
- Outside RUN, `dram_address`/`dram_wdata` come from sequencer registers. When no access is in progress they hold their last value.

## Timing
- Reset values: state=IDLE; `tx_valid`, `tx_data`, `enable_processor`, `dram_address`, `dram_wdata`, `dram_we`, `busy`, `done` all 0; pointers 0.
- Reset in any state (mid-LOAD, mid-RUN, or during DUMP_TX with `tx_valid` high):
  - all of the above is true in the cycle after `reset` is sampled;
  - any pending DRAM write is dropped.
- `start` to LOAD: 1 cycle.
- Rx byte to DRAM write: 1 cycle.
- `processor_done` to `enable_processor` low: 1 cycle. The processor's write in the `processor_done` cycle still passes through.
- Dump cost: 3 cycles per byte plus the Tx stall cycles. `tx_valid` never drops without a handshake.
- `rx_valid` on the final LOAD byte is written. An `rx_valid` in the first RUN cycle is dropped.

## Test plan
- Reset, then `start`, then 4 bytes 0x11,0x22,0x33,0x44 on consecutive cycles (`LOAD_BYTES`=4) -> DRAM[0..3]=11,22,33,44; state=RUN and `enable_processor`=1 one cycle after the last write.
- In RUN, drive processor write addr 0x0010, data 0xA5, `write_DRAM`=1 -> DRAM[0x10]=A5. The same strobe driven in IDLE produces `dram_we`=0.
- `processor_done` with `DUMP_BASE`=0x10, `DUMP_BYTES`=2, DRAM[0x10..0x11]=A5,5A, `tx_ready` tied 1 -> Tx bytes A5 then 5A, each 3 cycles apart; then `done`=1.
- `tx_ready` held low for 5 cycles in DUMP_TX -> `tx_valid` and `tx_data` stay stable; exactly one byte is transferred when `tx_ready` rises.
- `reset` asserted during LOAD after 2 bytes, then a fresh `start` -> the load restarts at address 0; all outputs were 0 in the cycle after reset.
- `start` in DONE -> LOAD with pointers cleared; `start` pulses during RUN are ignored.
